// File: rtl/pulse_measure_if.sv
// Pulse measurement bus: the stimulus and control side (master) and the measurement
// results (slave = pulse_measure).
//   pulse_in       pulse train under test
//   start          1-cycle strobe: clear results, arm measurement
//   target_count   pulses to complete before done (0 = no target)
//   timeout_cycles stall limit in cycles while armed (0 = never)
//   busy/done/timeout, pulse_count, last_width, last_gap, high_total  results
interface pulse_measure_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned REP_W = 16
);
    logic             pulse_in;
    logic             start;
    logic [REP_W-1:0] target_count;
    logic [CNT_W-1:0] timeout_cycles;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [REP_W-1:0] pulse_count;
    logic [CNT_W-1:0] last_width;
    logic [CNT_W-1:0] last_gap;
    logic [CNT_W-1:0] high_total;

    modport master (
        output pulse_in, start, target_count, timeout_cycles,
        input  busy, done, timeout, pulse_count, last_width, last_gap, high_total
    );

    modport slave (
        input  pulse_in, start, target_count, timeout_cycles,
        output busy, done, timeout, pulse_count, last_width, last_gap, high_total
    );
endinterface

// File: rtl/pulse_measure.sv
// Pulse train monitor: counts completed pulses, records the last high width, the last
// low gap and the accumulated high time; flags done after a programmed pulse count or
// timeout when no edge arrives for timeout_cycles while armed.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   bus (slave)   pulse_in/start/target_count/timeout_cycles in; results out
// Configuration:
//   PULSE_MEASURE_SYNC_EN  2-flop synchroniser on pulse_in (adds 2 cycles of latency)
module pulse_measure #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned REP_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    pulse_measure_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_LOW  = 3'd1;
    localparam logic [2:0] WAIT_RISE = 3'd2;
    localparam logic [2:0] HIGH      = 3'd3;
    localparam logic [2:0] LOW       = 3'd4;

    logic s;

`ifdef PULSE_MEASURE_SYNC_EN
    // Two-stage synchroniser for pulse sources outside this clock domain
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], bus.pulse_in};
    end
    assign s = sync_q[1];
`else
    assign s = bus.pulse_in;
`endif

    logic [2:0]       state, state_nxt;
    logic             prev, prev_nxt;
    logic             busy_q, busy_nxt, done_q, done_nxt, tmo_q, tmo_nxt;
    logic [REP_W-1:0] count_q, count_nxt, target_q, target_nxt;
    logic [CNT_W-1:0] width_q, width_nxt, gap_q, gap_nxt, total_q, total_nxt;
    logic [CNT_W-1:0] width_cnt, width_cnt_nxt, gap_cnt, gap_cnt_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt, tmo_lim, tmo_lim_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic             rise, fall;
    logic [REP_W-1:0] count_inc;
    logic [CNT_W-1:0] idle_inc;
    logic [CNT_W:0]   total_sum;

    assign rise      = s & ~prev;
    assign fall      = ~s & prev;
    assign count_inc = (count_q == '1) ? count_q : count_q + REP_W'(1);
    assign idle_inc  = sat_inc(idle_cnt);
    assign total_sum = {1'b0, total_q} + {1'b0, width_cnt};

    // Next-state and result update
    always_comb begin
        state_nxt     = state;
        prev_nxt      = s;
        busy_nxt      = busy_q;
        done_nxt      = done_q;
        tmo_nxt       = tmo_q;
        count_nxt     = count_q;
        target_nxt    = target_q;
        width_nxt     = width_q;
        gap_nxt       = gap_q;
        total_nxt     = total_q;
        width_cnt_nxt = width_cnt;
        gap_cnt_nxt   = gap_cnt;
        idle_cnt_nxt  = idle_cnt;
        tmo_lim_nxt   = tmo_lim;

        if (bus.start) begin
            // Start overrides any coincident edge; that edge only seeds prev
            busy_nxt      = 1'b1;
            done_nxt      = 1'b0;
            tmo_nxt       = 1'b0;
            count_nxt     = '0;
            width_nxt     = '0;
            gap_nxt       = '0;
            total_nxt     = '0;
            width_cnt_nxt = '0;
            gap_cnt_nxt   = '0;
            idle_cnt_nxt  = '0;
            target_nxt    = bus.target_count;
            tmo_lim_nxt   = bus.timeout_cycles;
            state_nxt     = s ? WAIT_LOW : WAIT_RISE;
        end else begin
            if (busy_q) idle_cnt_nxt = (rise | fall) ? '0 : idle_inc;

            case (state)
                WAIT_LOW:  if (fall) state_nxt = WAIT_RISE;
                WAIT_RISE: begin
                    if (rise) begin
                        width_cnt_nxt = CNT_W'(1);
                        state_nxt     = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        width_nxt   = width_cnt;
                        total_nxt   = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
                        count_nxt   = count_inc;
                        gap_cnt_nxt = CNT_W'(1);
                        state_nxt   = LOW;
                        if (target_q != '0 && count_inc == target_q) begin
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        width_cnt_nxt = sat_inc(width_cnt);
                    end
                end
                LOW: begin
                    if (rise) begin
                        gap_nxt       = gap_cnt;
                        width_cnt_nxt = CNT_W'(1);
                        state_nxt     = HIGH;
                    end else begin
                        gap_cnt_nxt = sat_inc(gap_cnt);
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // Stall: no edge for tmo_lim consecutive armed cycles
            if (busy_q && !(rise | fall) && tmo_lim != '0 && idle_inc == tmo_lim) begin
                tmo_nxt   = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prev      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            count_q   <= '0;
            target_q  <= '0;
            width_q   <= '0;
            gap_q     <= '0;
            total_q   <= '0;
            width_cnt <= '0;
            gap_cnt   <= '0;
            idle_cnt  <= '0;
            tmo_lim   <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            tmo_q     <= tmo_nxt;
            count_q   <= count_nxt;
            target_q  <= target_nxt;
            width_q   <= width_nxt;
            gap_q     <= gap_nxt;
            total_q   <= total_nxt;
            width_cnt <= width_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            idle_cnt  <= idle_cnt_nxt;
            tmo_lim   <= tmo_lim_nxt;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = tmo_q;
    assign bus.pulse_count = count_q;
    assign bus.last_width  = width_q;
    assign bus.last_gap    = gap_q;
    assign bus.high_total  = total_q;
endmodule

// File: tb/tb_pulse_measure.sv
// Testbench for pulse_measure: a wide instance (CNT_W=32, REP_W=16) and a narrow one
// (CNT_W=4, REP_W=2) share pulse_in/start; expected results are queued as each train
// is driven and compared when the selected instance drops busy.
module tb_pulse_measure;
`ifdef PULSE_MEASURE_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pulse_measure_if #(.CNT_W(32), .REP_W(16)) mif ();
    pulse_measure_if #(.CNT_W(4),  .REP_W(2))  sif ();

    assign sif.pulse_in = mif.pulse_in;
    assign sif.start    = mif.start;

    pulse_measure #(.CNT_W(32), .REP_W(16)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mif)
    );

    pulse_measure #(.CNT_W(4), .REP_W(2)) u_small (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif)
    );

    typedef struct {
        bit          sel;
        string       name;
        bit          done;
        bit          tmo;
        int unsigned count;
        int unsigned width;
        int unsigned gap;
        int unsigned total;
        int unsigned wait_n;
    } exp_t;

    exp_t sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;

    // One clock cycle: inputs change at the falling edge, sampled at the next rising edge
    task automatic cyc(input logic lvl, input logic st);
        @(negedge clk);
        mif.pulse_in = lvl;
        mif.start    = st;
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) cyc(lvl, 1'b0);
    endtask

    task automatic arm(input logic [15:0] tgt, input logic [31:0] tmo, input logic lvl);
        mif.target_count   = tgt;
        mif.timeout_cycles = tmo;
        cyc(lvl, 1'b1);
    endtask

    task automatic push(input bit sel, input string name, input bit d, input bit t,
                        input int unsigned c, input int unsigned w, input int unsigned g,
                        input int unsigned h, input int unsigned n);
        exp_t e;
        e.sel = sel; e.name = name; e.done = d; e.tmo = t;
        e.count = c; e.width = w; e.gap = g; e.total = h; e.wait_n = n;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the selected instance to finish, then compare against the queue head
    task automatic wait_result();
        exp_t e;
        int unsigned n;
        logic b, d, t;
        int unsigned c, w, g, h;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got=0 entries exp=1");
            return;
        end
        e = sb.pop_front();
        n = 0;
        do begin
            cyc(mif.pulse_in, 1'b0);
            n++;
            b = e.sel ? sif.busy : mif.busy;
        end while (b && n < 2000);
        d = e.sel ? sif.done    : mif.done;
        t = e.sel ? sif.timeout : mif.timeout;
        c = e.sel ? 32'(sif.pulse_count) : 32'(mif.pulse_count);
        w = e.sel ? 32'(sif.last_width)  : mif.last_width;
        g = e.sel ? 32'(sif.last_gap)    : mif.last_gap;
        h = e.sel ? 32'(sif.high_total)  : mif.high_total;
        if (n !== e.wait_n) begin bad++; $display("FAIL %s.latency got=%0d exp=%0d", e.name, n, e.wait_n); end
        total++;
        if (d !== e.done) begin bad++; $display("FAIL %s.done got=%0b exp=%0b", e.name, d, e.done); end
        total++;
        if (t !== e.tmo) begin bad++; $display("FAIL %s.timeout got=%0b exp=%0b", e.name, t, e.tmo); end
        total++;
        if (c !== e.count) begin bad++; $display("FAIL %s.pulse_count got=%0d exp=%0d", e.name, c, e.count); end
        total++;
        if (w !== e.width) begin bad++; $display("FAIL %s.last_width got=%0d exp=%0d", e.name, w, e.width); end
        total++;
        if (g !== e.gap) begin bad++; $display("FAIL %s.last_gap got=%0d exp=%0d", e.name, g, e.gap); end
        total++;
        if (h !== e.total) begin bad++; $display("FAIL %s.high_total got=%0d exp=%0d", e.name, h, e.total); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({mif.busy, mif.done, mif.timeout} !== 3'b000) begin
            bad++; $display("FAIL reset.flags got=%b exp=000", {mif.busy, mif.done, mif.timeout});
        end
        total++;
        if (mif.pulse_count !== 16'd0 || mif.last_width !== 32'd0 || mif.last_gap !== 32'd0 || mif.high_total !== 32'd0) begin
            bad++; $display("FAIL reset.results got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                            mif.pulse_count, mif.last_width, mif.last_gap, mif.high_total);
        end
        reset_n = 1'b1;
        hold(1'b0, 4);
    endtask

    task automatic test_single();
        arm(16'd1, 32'd0, 1'b0);
        cyc(1'b0, 1'b0);
        total++;
        if (mif.busy !== 1'b1) begin bad++; $display("FAIL single.busy got=%0b exp=1", mif.busy); end
        hold(1'b0, 1);
        hold(1'b1, 2);
        push(1'b0, "single", 1'b1, 1'b0, 1, 2, 0, 2, 1 + LAT);
        cyc(1'b0, 1'b0);
        wait_result();
    endtask

    task automatic test_train();
        arm(16'd3, 32'd0, 1'b0);
        cyc(1'b0, 1'b0);
        total++;
        if ({mif.busy, mif.done} !== 2'b10) begin
            bad++; $display("FAIL train.restart got=%b exp=10", {mif.busy, mif.done});
        end
        hold(1'b0, 2);
        for (int p = 0; p < 3; p++) begin
            hold(1'b1, 4);
            if (p < 2) hold(1'b0, 6);
        end
        push(1'b0, "train", 1'b1, 1'b0, 3, 4, 6, 12, 1 + LAT);
        cyc(1'b0, 1'b0);
        wait_result();
    endtask

    task automatic test_start_high();
        hold(1'b1, 4);
        arm(16'd1, 32'd0, 1'b1);
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 3);
        push(1'b0, "start_high", 1'b1, 1'b0, 1, 3, 0, 3, 1 + LAT);
        cyc(1'b0, 1'b0);
        wait_result();
    endtask

    // Start lands on the cycle the rising edge is sampled: that pulse must not count
    task automatic test_start_edge();
        hold(1'b0, 4);
        for (int i = 0; i < int'(LAT); i++) cyc(1'b1, 1'b0);
        arm(16'd1, 32'd0, 1'b1);
        hold(1'b1, 5);
        hold(1'b0, 2);
        hold(1'b1, 3);
        push(1'b0, "start_edge", 1'b1, 1'b0, 1, 3, 0, 3, 1 + LAT);
        cyc(1'b0, 1'b0);
        wait_result();
    endtask

    task automatic test_timeout();
        hold(1'b0, 3);
        arm(16'd5, 32'd50, 1'b0);
        hold(1'b0, 2);
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, 3);
        push(1'b0, "timeout", 1'b0, 1'b1, 2, 3, 4, 6, 1 + 50 + LAT);
        cyc(1'b0, 1'b0);
        wait_result();
        // Results are held once stopped, even if the train resumes
        hold(1'b1, 2);
        hold(1'b0, 4);
        total++;
        if (mif.pulse_count !== 16'd2 || mif.timeout !== 1'b1) begin
            bad++; $display("FAIL timeout.hold got=%0d/%0b exp=2/1", mif.pulse_count, mif.timeout);
        end
    endtask

    task automatic test_saturation();
        sif.target_count   = 2'd1;
        sif.timeout_cycles = 4'd0;
        arm(16'd0, 32'd0, 1'b0);
        hold(1'b0, 2);
        hold(1'b1, 20);
        push(1'b1, "sat_width", 1'b1, 1'b0, 1, 15, 0, 15, 1 + LAT);
        cyc(1'b0, 1'b0);
        wait_result();

        hold(1'b0, 3);
        sif.target_count   = 2'd0;
        sif.timeout_cycles = 4'd15;
        arm(16'd0, 32'd0, 1'b0);
        hold(1'b0, 2);
        for (int p = 0; p < 4; p++) begin
            hold(1'b1, 5);
            if (p < 3) hold(1'b0, 3);
        end
        push(1'b1, "sat_count", 1'b0, 1'b1, 3, 5, 3, 15, 1 + 15 + LAT);
        cyc(1'b0, 1'b0);
        wait_result();
    endtask

    task automatic test_reset_mid();
        hold(1'b0, 3);
        arm(16'd0, 32'd0, 1'b0);
        hold(1'b0, 2);
        hold(1'b1, 3);
        hold(1'b0, 2);
        hold(1'b1, 4);
        total++;
        if (mif.busy !== 1'b1 || mif.pulse_count !== 16'd1) begin
            bad++; $display("FAIL reset_mid.pre got=%0b/%0d exp=1/1", mif.busy, mif.pulse_count);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({mif.busy, mif.done, mif.timeout} !== 3'b000 || mif.pulse_count !== 16'd0 ||
            mif.last_width !== 32'd0 || mif.last_gap !== 32'd0 || mif.high_total !== 32'd0) begin
            bad++; $display("FAIL reset_mid.clear got=%b/%0d/%0d/%0d/%0d exp=000/0/0/0/0",
                            {mif.busy, mif.done, mif.timeout}, mif.pulse_count,
                            mif.last_width, mif.last_gap, mif.high_total);
        end
        mif.pulse_in = 1'b0;
        hold(1'b0, 2);
        reset_n = 1'b1;
        hold(1'b0, 3);
    endtask

    // Restart mid-LOW, then change target after start (must be ignored)
    task automatic test_back_to_back();
        arm(16'd0, 32'd0, 1'b0);
        hold(1'b0, 2);
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, 2);
        hold(1'b0, 2);
        total++;
        if (mif.pulse_count !== 16'(2 - (LAT > 1 ? 1 : 0)) && mif.pulse_count !== 16'd2) begin
            bad++; $display("FAIL restart.pre got=%0d exp=2", mif.pulse_count);
        end
        hold(1'b0, LAT);
        arm(16'd1, 32'd0, 1'b0);
        cyc(1'b0, 1'b0);
        total++;
        if (mif.busy !== 1'b1 || mif.pulse_count !== 16'd0 || mif.last_width !== 32'd0 ||
            mif.last_gap !== 32'd0 || mif.high_total !== 32'd0) begin
            bad++; $display("FAIL restart.clear got=%0b/%0d/%0d/%0d/%0d exp=1/0/0/0/0",
                            mif.busy, mif.pulse_count, mif.last_width, mif.last_gap, mif.high_total);
        end
        mif.target_count = 16'd7;
        hold(1'b0, 1);
        hold(1'b1, 2);
        push(1'b0, "restart", 1'b1, 1'b0, 1, 2, 0, 2, 1 + LAT);
        cyc(1'b0, 1'b0);
        wait_result();
    endtask

    initial begin
        mif.pulse_in       = 1'b0;
        mif.start          = 1'b0;
        mif.target_count   = 16'd0;
        mif.timeout_cycles = 32'd0;
        sif.target_count   = 2'd0;
        sif.timeout_cycles = 4'd0;
        test_reset();
        test_single();
        test_train();
        test_start_high();
        test_start_edge();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
